// File: rtl/video_pkg.sv
// Shared definitions for the video processor control path.
//   - Decoded opcode values seen by the instruction execution unit.
//   - exec_state_t: states of the instruction execution FSM.
package video_pkg;

    localparam logic [3:0] OP_SET_POS    = 4'b0000;
    localparam logic [3:0] OP_WR_MEM     = 4'b0001;
    localparam logic [3:0] OP_SET_OFF    = 4'b0010;
    localparam logic [3:0] OP_WAIT_FRAME = 4'b0011;
    localparam logic [3:0] OP_NOP        = 4'b1111;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_EXEC       = 3'd1,
        ST_WR_MEM     = 3'd2,
        ST_WAIT_FRAME = 3'd3,
        ST_DONE       = 3'd4
    } exec_state_t;

endpackage

// File: rtl/exec_if.sv
// Decoder <-> execution-unit handshake.
//   instr_valid/opcode/register/data : decoded instruction, from the decoder
//   new_instruction                  : busy flag back to the decoder
//   done                             : one-cycle completion pulse
// Handshake: an instruction is accepted on a rising clk edge where
// instr_valid=1 and new_instruction=0. While new_instruction=1 the
// instr_valid line is ignored (nothing is queued); the decoder must
// re-present the instruction after new_instruction returns to 0.
interface exec_if;
    logic        instr_valid;
    logic [3:0]  opcode;
    logic [13:0] register;
    logic [31:0] data;
    logic        new_instruction;
    logic        done;

    modport master (
        output instr_valid, opcode, register, data,
        input  new_instruction, done
    );

    modport slave (
        input  instr_valid, opcode, register, data,
        output new_instruction, done
    );
endinterface

// File: rtl/instruction_exec_unit.sv
// Instruction execution unit: sequences register-bank and sprite-memory
// writes for decoded instructions and pulses done on completion.
// Ports:
//   clk, reset       : clock; synchronous active-low reset
//   dec (slave)      : decoder handshake (instr_valid/opcode/register/data in,
//                      new_instruction/done out)
//   vsync            : one-cycle frame-start pulse
//   reg_*            : register-bank write strobe, field select, address, data
//   mem_*            : sprite-memory write enable, address, data
//   timeout_err      : sticky WAIT_FRAME timeout flag
//   fsm_state        : current FSM state, for observation
// Build option: define WAIT_TIMEOUT_EN to let WAIT_FRAME give up after
// TIMEOUT_CYC cycles without vsync (sets timeout_err). Otherwise it waits
// indefinitely and timeout_err is tied low.
module instruction_exec_unit
    import video_pkg::*;
#(
    parameter int REG_AW        = 5,
    parameter int MEM_AW        = 14,
    parameter int COLOR_W       = 9,
    parameter int MEM_WR_CYCLES = 2,
    parameter int TIMEOUT_CYC   = 1024
) (
    input  logic               clk,
    input  logic               reset,
    exec_if.slave              dec,
    input  logic               vsync,
    output logic               reg_wr_en,
    output logic               reg_sel,
    output logic [REG_AW-1:0]  reg_addr,
    output logic [31:0]        reg_wr_data,
    output logic               mem_wr_en,
    output logic [MEM_AW-1:0]  mem_addr,
    output logic [COLOR_W-1:0] mem_wr_data,
    output logic               timeout_err,
    output exec_state_t        fsm_state
);

    localparam int             WR_CW   = (MEM_WR_CYCLES > 1) ? $clog2(MEM_WR_CYCLES) : 1;
    localparam logic [WR_CW-1:0] WR_LOAD = WR_CW'(MEM_WR_CYCLES - 1);

    exec_state_t      state, next_state;
    logic [3:0]       op_q;
    logic [WR_CW-1:0] wr_cnt;
    logic             wait_expired;

    // Address/data outputs are registers loaded at accept time, so they are
    // already valid in EXEC and keep their last value afterwards. Only the
    // fields belonging to the accepted opcode's target are updated.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= ST_IDLE;
            op_q        <= '0;
            reg_sel     <= 1'b0;
            reg_addr    <= '0;
            reg_wr_data <= '0;
            mem_addr    <= '0;
            mem_wr_data <= '0;
            wr_cnt      <= '0;
        end else begin
            state <= next_state;
            if (state == ST_IDLE && dec.instr_valid) begin
                op_q <= dec.opcode;
                if (dec.opcode == OP_SET_POS || dec.opcode == OP_SET_OFF) begin
                    reg_sel     <= (dec.opcode == OP_SET_OFF);
                    reg_addr    <= dec.register[REG_AW-1:0];
                    reg_wr_data <= dec.data;
                end
                if (dec.opcode == OP_WR_MEM) begin
                    mem_addr    <= dec.register[MEM_AW-1:0];
                    mem_wr_data <= dec.data[COLOR_W-1:0];
                end
            end
            // Down-counter preloaded in EXEC; WR_MEM leaves when it reads 0.
            if (state == ST_EXEC)
                wr_cnt <= WR_LOAD;
            else if (state == ST_WR_MEM && wr_cnt != '0)
                wr_cnt <= wr_cnt - 1'b1;
        end
    end

`ifdef WAIT_TIMEOUT_EN
    localparam int TO_CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    logic [TO_CW-1:0] wait_cnt;

    // Counts cycles spent in WAIT_FRAME, starting from 0 on entry.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (state == ST_WAIT_FRAME)
                wait_cnt <= wait_cnt + 1'b1;
            else
                wait_cnt <= '0;
            if (wait_expired)
                timeout_err <= 1'b1;
        end
    end

    // vsync takes priority on the final cycle: a frame start is not a timeout.
    assign wait_expired = (state == ST_WAIT_FRAME) && !vsync &&
                          (wait_cnt == TO_CW'(TIMEOUT_CYC - 1));
`else
    assign wait_expired = 1'b0;
    assign timeout_err  = 1'b0;
`endif

    always_comb begin
        next_state = state;
        reg_wr_en  = 1'b0;
        mem_wr_en  = 1'b0;
        dec.done   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (dec.instr_valid) next_state = ST_EXEC;
            end
            ST_EXEC: begin
                case (op_q)
                    OP_SET_POS, OP_SET_OFF: begin
                        reg_wr_en  = 1'b1;
                        next_state = ST_DONE;
                    end
                    OP_WR_MEM:     next_state = ST_WR_MEM;
                    OP_WAIT_FRAME: next_state = ST_WAIT_FRAME;
                    default:       next_state = ST_DONE;
                endcase
            end
            ST_WR_MEM: begin
                mem_wr_en = 1'b1;
                if (wr_cnt == '0) next_state = ST_DONE;
            end
            ST_WAIT_FRAME: begin
                // vsync in the EXEC cycle is never seen here: only sampled in this state.
                if (vsync || wait_expired) next_state = ST_DONE;
            end
            ST_DONE: begin
                dec.done   = 1'b1;
                next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Held busy while reset is applied so the decoder never issues into reset.
    assign dec.new_instruction = (state != ST_IDLE) || !reset;
    assign fsm_state           = state;

endmodule
